esm_issue_ctrl: RTL
===================

// Module: esm_issue_ctrl
// PURPOSE
// - Downstream of the dependency-analysis stage. Holds the instruction buffer and per-slot lifecycle state.
// - Consumes the per-slot "no outstanding dependency" vector and issues one ready instruction per cycle to execute.
// - Retires completed slots; tells the dependency stage which IDT column to clear.
// PARAMETERS
// - IW   32  instruction word width
// - BS   16  buffer slots (power of 2); BSB = $clog2(BS)
// PORTS
// - clk        in   1    clock
// - rst        in   1    reset, asynchronous, active-high
// - alloc_vld  in   1    write alloc_instr into slot alloc_idx (same index the dependency stage receives)
// - alloc_idx  in   BSB  target slot
// - alloc_instr in  IW   instruction word
// - alloc_err  out  1    1-cycle pulse: alloc to non-FREE slot, write dropped
// - rdy_mask   in   BS   bit i=1: IDT row i is all-zero
// - iss_vld    out  1    issue valid (registered)
// - iss_rdy    in   1    execute accepts
// - iss_idx    out  BSB  slot of issued instruction
// - iss_instr  out  IW   issued instruction word
// - cmp_vld    in   1    execute completion
// - cmp_idx    in   BSB  completed slot
// - clr_vld    out  1    1-cycle pulse: clear dependency column clr_idx
// - clr_idx    out  BSB  freed slot
// - occ_cnt    out  BSB+1  number of non-FREE slots
// BEHAVIOUR
// - Slot states: FREE -> WAIT (alloc) -> SEL (picked, in output reg) -> EXEC (iss handshake) -> FREE (cmp).
// - Reset: all slots FREE; iss_vld=0, clr_vld=0, alloc_err=0, occ_cnt=0, iss_idx=0, iss_instr=0, rr_ptr=0.
// - Candidate set: slot WAIT and rdy_mask[i]. Pick the first candidate scanning rr_ptr, rr_ptr+1, ... with wrap mod BS.
// - Selection happens when output reg is empty or is being handshaken this cycle (iss_vld&&iss_rdy) -> 1 issue/cycle.
// - Latency: candidate at edge N -> iss_vld=1 with idx/instr after edge N. Slot goes to SEL; rr_ptr <= pick+1 (wraps).
// - iss_vld && !iss_rdy: iss_idx/iss_instr held stable, no new pick, rdy_mask ignored.
// - Handshake: SEL slot -> EXEC; iss_vld drops unless a new pick is loaded the same edge.
// - cmp_vld with slot in EXEC: slot -> FREE; clr_vld=1, clr_idx=cmp_idx on next cycle. Otherwise ignored, no clr.
// - alloc_vld: slot state sampled before this edge's updates. FREE -> WAIT, store instr. Else alloc_err pulse, no change.
// - alloc and cmp to the same slot in one cycle: cmp wins, alloc rejected with alloc_err.
// - A slot allocated at edge N is never a candidate before edge N+1.
// - occ_cnt: +1 on accepted alloc, -1 on accepted cmp, both -> unchanged; range 0..BS.
// - rdy_mask bit for FREE/SEL/EXEC slots is don't-care.
// - rst mid-operation: all state cleared immediately; an in-flight issue is abandoned.
// CONFIGURATION
// - ESM_ISSUE_STATS_EN defined: adds outputs issue_cnt[31:0] and stall_cnt[31:0].
//   - issue_cnt: +1 per handshake.
//   - stall_cnt: +1 per cycle with iss_vld && !iss_rdy.
//   - Both wrap at 2^32; both reset to 0.
// - Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - Shared package esm_pkg:
//   - slot_state_t enum {FREE, WAIT, SEL, EXEC} (2 bits).
//   - BS/BSB defaults; idx_t typedef.
// - Sub-module esm_rr_picker #(BS): combinational rotating-priority pick.
//   - in: req[BS], ptr[BSB]; out: gnt_vld, gnt_idx.
// - Top: slot-state array, instr RAM (BS x IW), output register, rr_ptr, occ_cnt, clr register.
// TESTING
// - Reset then alloc slots 0..3; rdy_mask=4'b1010 -> iss_idx=1 next cycle, then 3; rr_ptr ends at 4.
// - iss_rdy=0 for 5 cycles with rdy_mask changing -> iss_idx/instr stable, stall_cnt=5 (STATS_EN).
// - Fill all 16 slots -> occ_cnt=16. Alloc slot 5 again -> alloc_err pulse, slot 5 instr unchanged.
// - cmp_idx=2 on an EXEC slot -> clr_vld=1, clr_idx=2 one cycle later; cmp on a WAIT slot -> no clr.
// - rr_ptr=15, candidates {15,0} -> picks 15 then 0, back-to-back with iss_rdy=1.
// - Same-cycle cmp_idx=7 and alloc_idx=7 -> slot 7 FREE, alloc_err=1; rst during iss_vld -> iss_vld=0 immediately.

Source files
------------

// File: rtl/esm_pkg.sv
// ============================================================================
// Package : esm_pkg
// Brief   : Shared slot lifecycle encoding and default sizes for the issue stage.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package esm_pkg;

  localparam int IW_DEF  = 32;
  localparam int BS_DEF  = 16;
  localparam int BSB_DEF = $clog2(BS_DEF);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    SEL  = 2'd2,
    EXEC = 2'd3
  } slot_state_t;

  typedef logic [BSB_DEF-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/esm_rr_picker.sv
// ============================================================================
// Module : esm_rr_picker
// Brief  : Rotating-priority picker; first set req bit at or after ptr, wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module esm_rr_picker #(
  parameter  int BS  = 16,
  localparam int BSB = $clog2(BS)
) (
  input  logic [BS-1:0]  req,
  input  logic [BSB-1:0] ptr,
  output logic           gnt_vld,
  output logic [BSB-1:0] gnt_idx
);

  logic [BSB-1:0] w_scan_idx;

  // Index arithmetic is BSB bits wide, so ptr + k wraps modulo BS for free.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    w_scan_idx = '0;
    for (int k = 0; k < BS; k++) begin
      w_scan_idx = ptr + BSB'(k);
      if (!gnt_vld && req[w_scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_scan_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/esm_issue_ctrl.sv
// ============================================================================
// Module : esm_issue_ctrl
// Brief  : Instruction buffer with per-slot lifecycle, 1-per-cycle issue, retire.
//          Optional counters issue_cnt/stall_cnt under `ESM_ISSUE_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module esm_issue_ctrl
  import esm_pkg::*;
#(
  parameter  int IW  = IW_DEF,
  parameter  int BS  = BS_DEF,
  localparam int BSB = $clog2(BS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc_vld,
  input  logic [BSB-1:0] alloc_idx,
  input  logic [IW-1:0]  alloc_instr,
  output logic           alloc_err,
  input  logic [BS-1:0]  rdy_mask,
  output logic           iss_vld,
  input  logic           iss_rdy,
  output logic [BSB-1:0] iss_idx,
  output logic [IW-1:0]  iss_instr,
  input  logic           cmp_vld,
  input  logic [BSB-1:0] cmp_idx,
  output logic           clr_vld,
  output logic [BSB-1:0] clr_idx,
  output logic [BSB:0]   occ_cnt
`ifdef ESM_ISSUE_STATS_EN
  ,
  output logic [31:0]    issue_cnt,
  output logic [31:0]    stall_cnt
`endif
);

  slot_state_t    slot_q [BS];
  slot_state_t    slot_d [BS];
  logic [IW-1:0]  mem_q  [BS];

  logic           iss_vld_q;
  logic [BSB-1:0] iss_idx_q;
  logic [IW-1:0]  iss_instr_q;
  logic [BSB-1:0] rr_ptr_q;
  logic [BSB:0]   occ_q;
  logic [BSB:0]   occ_d;
  logic           clr_vld_q;
  logic [BSB-1:0] clr_idx_q;
  logic           alloc_err_q;

  logic [BS-1:0]  w_req;
  logic           w_pick_vld;
  logic [BSB-1:0] w_pick_idx;
  logic           w_hs;
  logic           w_load;
  logic           w_cmp_acc;
  logic           w_alloc_acc;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < BS; i++) begin
      w_req[i] = (slot_q[i] == WAIT) && rdy_mask[i];
    end
  end

  esm_rr_picker #(.BS(BS)) u_picker (
    .req     (w_req),
    .ptr     (rr_ptr_q),
    .gnt_vld (w_pick_vld),
    .gnt_idx (w_pick_idx)
  );

  assign w_hs   = iss_vld_q && iss_rdy;
  assign w_load = (!iss_vld_q || iss_rdy) && w_pick_vld;

  // An alloc colliding with a cmp on the same slot sees EXEC, never FREE, so cmp wins.
  assign w_cmp_acc   = cmp_vld   && (slot_q[cmp_idx]   == EXEC);
  assign w_alloc_acc = alloc_vld && (slot_q[alloc_idx] == FREE);

  // The four transitions always target slots in distinct states, so order is irrelevant.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (w_hs)        slot_d[iss_idx_q]  = EXEC;
    if (w_cmp_acc)   slot_d[cmp_idx]    = FREE;
    if (w_alloc_acc) slot_d[alloc_idx]  = WAIT;
    if (w_load)      slot_d[w_pick_idx] = SEL;
  end

  always_comb begin
    occ_d = occ_q;
    case ({w_alloc_acc, w_cmp_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        slot_q[i] <= FREE;
      end
      iss_vld_q   <= 1'b0;
      iss_idx_q   <= '0;
      iss_instr_q <= '0;
      rr_ptr_q    <= '0;
      occ_q       <= '0;
      clr_vld_q   <= 1'b0;
      clr_idx_q   <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      if (w_load) begin
        iss_vld_q   <= 1'b1;
        iss_idx_q   <= w_pick_idx;
        iss_instr_q <= mem_q[w_pick_idx];
        rr_ptr_q    <= w_pick_idx + 1'b1;
      end else if (w_hs) begin
        iss_vld_q   <= 1'b0;
      end
      occ_q       <= occ_d;
      clr_vld_q   <= w_cmp_acc;
      if (w_cmp_acc) clr_idx_q <= cmp_idx;
      alloc_err_q <= alloc_vld && !w_alloc_acc;
    end
  end

  // Instruction storage is only read for WAIT slots, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc_acc) mem_q[alloc_idx] <= alloc_instr;
  end

`ifdef ESM_ISSUE_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (w_hs)                  issue_cnt_q <= issue_cnt_q + 1'b1;
      if (iss_vld_q && !iss_rdy) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign iss_vld   = iss_vld_q;
  assign iss_idx   = iss_idx_q;
  assign iss_instr = iss_instr_q;
  assign clr_vld   = clr_vld_q;
  assign clr_idx   = clr_idx_q;
  assign alloc_err = alloc_err_q;
  assign occ_cnt   = occ_q;

endmodule

`default_nettype wire
